// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life LED scanner: grid geometry,
// scan state encoding and a helper that extracts one row of a generation.
// Pure declarations; no latency and no flow control of its own.
package gol_pkg;

    localparam int GRID_W    = 64;  // one 8x8 generation, row-major
    localparam int ROW_W     = 8;   // columns per row
    localparam int NROWS     = 8;   // rows per frame
    localparam int ROW_IDX_W = 3;   // row index width, wraps 7 -> 0

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,  // nothing captured yet, display dark
        S_GAP   = 2'd1,  // all rows off between two rows (anti-ghosting)
        S_DRIVE = 2'd2   // one row enabled with its column data
    } scan_state_t;

    // Row r occupies grid[8r+7:8r]; bit c of the slice is column c.
    // The index is built by concatenation because ROW_W is fixed at 8.
    function automatic logic [ROW_W-1:0] row_of(input logic [GRID_W-1:0]    g,
                                                input logic [ROW_IDX_W-1:0] r);
        return g[{r, 3'b000} +: ROW_W];
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter timing the GAP and DRIVE intervals of the scanner.
// Latency: done rises load_val cycles after the load cycle (load_val=1 -> next cycle).
// No backpressure; a load always wins over the running count.
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   load        start a new interval of load_val cycles
//   load_val    interval length in cycles (0 is treated as 1)
//   done        high on the final cycle of the interval (stays high while idle)
module dwell_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // The count holds "cycles remaining after this one", so an interval of
    // N cycles loads N-1 and reports done when it reaches zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val == '0) ? '0 : load_val - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/gol_led_scanner.sv
// Double-buffers Game-of-Life generations and row-scans them onto an 8x8 LED matrix.
// Latency: row_n/col/frame_done are registered, one cycle behind the scan state.
// No backpressure: grid_valid is always accepted; the newest generation wins.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   grid         current generation, row r = grid[8r+7:8r], bit c = column c
//   grid_valid   one-cycle pulse marking a new generation on grid
//   blank        forces the matrix dark without disturbing scan timing
//   row_n        active-low one-hot row enable
//   col          active-high column data for the enabled row
//   frame_done   one-cycle pulse on the last visible cycle of row 7
//   stable       latest generation equals the previous one
//   gen_count    saturating count of generations received
module gol_led_scanner
    import gol_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int GAP   = 1,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] grid,
    input  logic              grid_valid,
    input  logic              blank,
    output logic [ROW_W-1:0]  row_n,
    output logic [ROW_W-1:0]  col,
    output logic              frame_done,
    output logic              stable,
    output logic [CNT_W-1:0]  gen_count
);

    localparam int MAXV = (DWELL > GAP) ? DWELL : GAP;
    localparam int TW   = $clog2(MAXV + 1);

    localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL);
    // With no gap, each row slot starts straight in S_DRIVE.
    localparam logic [TW-1:0] SLOT_LOAD  = (GAP == 0) ? TW'(DWELL) : TW'(GAP);
    localparam scan_state_t   SLOT_STATE = (GAP == 0) ? S_DRIVE : S_GAP;
    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(NROWS - 1);

    scan_state_t          state;
    scan_state_t          state_nx;
    logic [ROW_IDX_W-1:0] row;
    logic [ROW_IDX_W-1:0] row_nx;

    logic [GRID_W-1:0]    shadow;    // newest generation, not yet shown
    logic [GRID_W-1:0]    display;   // generation being scanned out
    logic                 pending;   // shadow holds something display has not taken
    logic                 have_prev; // at least one generation seen since reset

    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_done;

    logic                 reload;    // display may swap at this edge
    logic                 frame_end; // last DRIVE cycle of row 7

    dwell_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // ------------------------------------------------------------------
    // Scan state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            row   <= '0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        row_nx    = row;
        tmr_load  = 1'b0;
        tmr_val   = DWELL_LOAD;
        reload    = 1'b0;
        frame_end = 1'b0;

        case (state)
            S_IDLE: begin
                // First generation arrived: start scanning at row 0.
                if (pending) begin
                    reload   = 1'b1;
                    row_nx   = '0;
                    state_nx = SLOT_STATE;
                    tmr_load = 1'b1;
                    tmr_val  = SLOT_LOAD;
                end
            end

            S_GAP: begin
                if (tmr_done) begin
                    state_nx = S_DRIVE;
                    tmr_load = 1'b1;
                    tmr_val  = DWELL_LOAD;
                end
            end

            S_DRIVE: begin
                if (tmr_done) begin
                    row_nx   = row + 1'b1;  // 7 wraps to 0
                    state_nx = SLOT_STATE;
                    tmr_load = 1'b1;
                    tmr_val  = SLOT_LOAD;
                    if (row == LAST_ROW) begin
                        reload    = 1'b1;
                        frame_end = 1'b1;
                    end
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture and double buffering
    // ------------------------------------------------------------------
    // The display buffer only moves at a reload edge, so a frame in
    // progress never tears. A generation arriving on the reload edge
    // itself is taken straight into display and never becomes pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow    <= '0;
            display   <= '0;
            pending   <= 1'b0;
            have_prev <= 1'b0;
            stable    <= 1'b0;
            gen_count <= '0;
        end else begin
            if (grid_valid) begin
                shadow    <= grid;
                stable    <= have_prev && (grid == shadow);
                have_prev <= 1'b1;
                if (gen_count != {CNT_W{1'b1}}) begin
                    gen_count <= gen_count + 1'b1;
                end
            end

            if (reload) begin
                if (grid_valid) begin
                    display <= grid;
                end else if (pending) begin
                    display <= shadow;
                end
                pending <= 1'b0;
            end else if (grid_valid) begin
                pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered matrix drive
    // ------------------------------------------------------------------
    // Driving the pins from flops keeps them glitch-free. Because they lag
    // the state by a cycle, frame_done is registered too so that it lines
    // up with the final visible cycle of row 7.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_n      <= '1;
            col        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if ((state == S_DRIVE) && !blank) begin
                row_n <= ~(ROW_W'(1) << row);
                col   <= row_of(display, row);
            end else begin
                row_n <= '1;
                col   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gol_led_scanner.sv
module tb_gol_led_scanner;

    localparam int DWELL = 4;
    localparam int GAP   = 1;
    localparam int CNT_W = 16;
    localparam int SLOT  = GAP + DWELL;
    localparam int FRAME = 8 * SLOT;

    logic              clk = 1'b0;
    logic              reset;
    logic [63:0]       grid;
    logic              grid_valid;
    logic              blank;
    logic [7:0]        row_n;
    logic [7:0]        col;
    logic              frame_done;
    logic              stable;
    logic [CNT_W-1:0]  gen_count;

    // Second instance with a 3-bit counter to reach saturation quickly.
    logic [7:0]        s_row_n;
    logic [7:0]        s_col;
    logic              s_frame_done;
    logic              s_stable;
    logic [2:0]        s_gen_count;

    int n_cmp = 0;
    int n_err = 0;

    gol_led_scanner #(.DWELL(DWELL), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .grid(grid), .grid_valid(grid_valid), .blank(blank),
        .row_n(row_n), .col(col), .frame_done(frame_done), .stable(stable), .gen_count(gen_count)
    );

    gol_led_scanner #(.DWELL(DWELL), .GAP(GAP), .CNT_W(3)) sdut (
        .clk(clk), .reset(reset), .grid(grid), .grid_valid(grid_valid), .blank(blank),
        .row_n(s_row_n), .col(s_col), .frame_done(s_frame_done), .stable(s_stable),
        .gen_count(s_gen_count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the scan is a position within a FRAME-cycle frame.
    // Position p lights row p/SLOT unless p%SLOT falls in the gap. The pins
    // show, after each edge, what the position before that edge called for.
    // ------------------------------------------------------------------
    bit          m_scan;
    int          m_pos;
    logic [63:0] m_shadow, m_disp;
    bit          m_pending, m_have_prev, m_stable;
    logic [15:0] m_count;
    logic [7:0]  e_row_n, e_col;
    bit          e_fd;

    task automatic model_reset();
        m_scan = 0; m_pos = 0; m_shadow = '0; m_disp = '0;
        m_pending = 0; m_have_prev = 0; m_stable = 0; m_count = '0;
        e_row_n = 8'hFF; e_col = 8'h00; e_fd = 0;
    endtask

    task automatic model_step();
        int r;
        bit lit, boundary;
        r   = m_pos / SLOT;
        lit = m_scan && ((m_pos % SLOT) >= GAP) && !blank;
        e_row_n = lit ? ~(8'd1 << r) : 8'hFF;
        e_col   = lit ? m_disp[8*r +: 8] : 8'h00;
        e_fd    = m_scan && (m_pos == FRAME - 1);
        boundary = (!m_scan && m_pending) || e_fd;
        if (boundary) m_disp = grid_valid ? grid : (m_pending ? m_shadow : m_disp);
        if (!m_scan && m_pending) begin
            m_scan = 1; m_pos = 0;
        end else if (m_scan) begin
            m_pos = (m_pos + 1) % FRAME;
        end
        if (grid_valid) begin
            m_stable    = m_have_prev && (grid == m_shadow);
            m_have_prev = 1;
            m_shadow    = grid;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end
        m_pending = boundary ? 0 : (grid_valid ? 1 : m_pending);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; grid_valid = 1'b0; blank = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({row_n, col, frame_done, stable} !== {8'hFF, 8'h00, 2'b00} || gen_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_vals: row_n=%h col=%h fd=%b st=%b cnt=%0d, need FF 00 0 0 0",
                     row_n, col, frame_done, stable, gen_count);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (row_n !== 8'hFF || col !== 8'h00 || frame_done !== 1'b0 || gen_count !== 16'd0) begin
                n_err++;
                $display("FAIL idle_dark c%0d: row_n=%h col=%h fd=%b cnt=%0d, need FF 00 0 0",
                         i, row_n, col, frame_done, gen_count);
            end
        end
    endtask

    task automatic test_first_frame();
        int fd_at;
        grid = 64'h0000_0000_0000_0702; grid_valid = 1'b1;
        tick();
        grid_valid = 1'b0;
        fd_at = 0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            n_cmp++;
            if ({row_n, col, frame_done} !== {e_row_n, e_col, e_fd}) begin
                n_err++;
                $display("FAIL first_frame c%0d: row_n/col/fd=%h/%h/%b need %h/%h/%b",
                         i, row_n, col, frame_done, e_row_n, e_col, e_fd);
            end
            if (i == 3 || i == 6) begin
                n_cmp++;
                if (row_n !== 8'hFE || col !== 8'h02) begin
                    n_err++;
                    $display("FAIL row0 c%0d: row_n=%h col=%h need FE 02", i, row_n, col);
                end
            end
            if (i == 8 || i == 11) begin
                n_cmp++;
                if (row_n !== 8'hFD || col !== 8'h07) begin
                    n_err++;
                    $display("FAIL row1 c%0d: row_n=%h col=%h need FD 07", i, row_n, col);
                end
            end
            if (i == 13) begin
                n_cmp++;
                if (row_n !== 8'hFB || col !== 8'h00) begin
                    n_err++;
                    $display("FAIL row2 c%0d: row_n=%h col=%h need FB 00", i, row_n, col);
                end
            end
            if (frame_done === 1'b1 && fd_at == 0) fd_at = i;
        end
        n_cmp++;
        if (fd_at != 41) begin
            n_err++;
            $display("FAIL fd_timing: first frame_done %0d edges after pulse, need 41", fd_at);
        end
    endtask

    task automatic test_mid_frame();
        int budget, nfd;
        budget = 2 * FRAME;
        while (!(m_scan && (m_pos / SLOT) == 3 && (m_pos % SLOT) >= GAP) && budget > 0) begin
            tick(); budget--;
        end
        if (budget == 0) begin
            n_cmp++; n_err++;
            $display("FAIL mid_wait: row 3 not reached, got budget %0d need >0", budget);
        end
        grid = 64'hFF00_0000_0000_0000; grid_valid = 1'b1;
        tick();
        grid_valid = 1'b0;
        nfd = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n_cmp++;
            if ({row_n, col, frame_done} !== {e_row_n, e_col, e_fd}) begin
                n_err++;
                $display("FAIL mid_frame c%0d: row_n/col/fd=%h/%h/%b need %h/%h/%b",
                         i, row_n, col, frame_done, e_row_n, e_col, e_fd);
            end
            if (row_n === 8'h7F) begin
                n_cmp++;
                if (col !== ((nfd == 0) ? 8'h00 : 8'hFF)) begin
                    n_err++;
                    $display("FAIL mid_row7 c%0d: col=%h need %h", i, col, (nfd == 0) ? 8'h00 : 8'hFF);
                end
            end
            if (frame_done === 1'b1) nfd++;
        end
    endtask

    task automatic test_stable();
        logic [63:0] x;
        bit   exp_st[3];
        logic [15:0] exp_cnt[3];
        exp_st  = '{1'b0, 1'b1, 1'b0};
        exp_cnt = '{16'd1, 16'd2, 16'd3};
        apply_reset();
        x = {$urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            grid = (k == 2) ? ~x : x; grid_valid = 1'b1;
            tick();
            grid_valid = 1'b0;
            n_cmp++;
            if (stable !== exp_st[k] || gen_count !== exp_cnt[k]) begin
                n_err++;
                $display("FAIL stable_seq k%0d: stable=%b cnt=%0d need %b %0d",
                         k, stable, gen_count, exp_st[k], exp_cnt[k]);
            end
            for (int j = 0; j < 3; j++) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_s;
        for (int k = 0; k < 10; k++) begin
            grid = {$urandom, $urandom}; grid_valid = 1'b1;
            tick();
            exp_s = (m_count > 16'd7) ? 3'd7 : m_count[2:0];
            n_cmp++;
            if (gen_count !== m_count || s_gen_count !== exp_s || stable !== m_stable) begin
                n_err++;
                $display("FAIL b2b_count k%0d: cnt=%0d small=%0d st=%b need %0d %0d %b",
                         k, gen_count, s_gen_count, stable, m_count, exp_s, m_stable);
            end
        end
        grid_valid = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) begin
            tick();
            n_cmp++;
            if ({row_n, col, frame_done} !== {e_row_n, e_col, e_fd}) begin
                n_err++;
                $display("FAIL b2b_scan c%0d: row_n/col/fd=%h/%h/%b need %h/%h/%b",
                         i, row_n, col, frame_done, e_row_n, e_col, e_fd);
            end
        end
    endtask

    task automatic test_bypass();
        int budget;
        logic [63:0] g;
        budget = 2 * FRAME;
        while (!(m_scan && m_pos == FRAME - 1) && budget > 0) begin
            tick(); budget--;
        end
        if (budget == 0) begin
            n_cmp++; n_err++;
            $display("FAIL bypass_wait: boundary not reached, got budget %0d need >0", budget);
        end
        g = {$urandom, $urandom};
        grid = g; grid_valid = 1'b1;
        tick();
        grid_valid = 1'b0;
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_fd: frame_done=%b need 1", frame_done);
        end
        budget = 20;
        while (row_n !== 8'hFE && budget > 0) begin
            tick(); budget--;
        end
        n_cmp++;
        if (row_n !== 8'hFE || col !== g[7:0]) begin
            n_err++;
            $display("FAIL bypass_row0: row_n=%h col=%h need FE %h", row_n, col, g[7:0]);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            n_cmp++;
            if ({row_n, col, frame_done} !== {e_row_n, e_col, e_fd}) begin
                n_err++;
                $display("FAIL bypass_scan c%0d: row_n/col/fd=%h/%h/%b need %h/%h/%b",
                         i, row_n, col, frame_done, e_row_n, e_col, e_fd);
            end
        end
    endtask

    task automatic test_blank();
        int last_fd, nfd;
        blank = 1'b1;
        last_fd = -1; nfd = 0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            tick();
            n_cmp++;
            if (row_n !== 8'hFF || col !== 8'h00 || frame_done !== e_fd) begin
                n_err++;
                $display("FAIL blank c%0d: row_n=%h col=%h fd=%b need FF 00 %b",
                         i, row_n, col, frame_done, e_fd);
            end
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    n_cmp++;
                    if (i - last_fd != FRAME) begin
                        n_err++;
                        $display("FAIL blank_period: %0d cycles between frame_done need %0d",
                                 i - last_fd, FRAME);
                    end
                end
                last_fd = i; nfd++;
            end
        end
        n_cmp++;
        if (nfd < 2) begin
            n_err++;
            $display("FAIL blank_fd_count: %0d pulses need >=2", nfd);
        end
        blank = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [2:0] exp_s;
        for (int i = 0; i < 800; i++) begin
            grid_valid = ($urandom_range(5) == 0);
            if ($urandom_range(2) != 0) grid = {$urandom, $urandom};
            blank = ($urandom_range(9) == 0);
            tick();
            exp_s = (m_count > 16'd7) ? 3'd7 : m_count[2:0];
            n_cmp++;
            if ({row_n, col, frame_done, stable} !== {e_row_n, e_col, e_fd, m_stable} ||
                gen_count !== m_count || s_gen_count !== exp_s ||
                {s_row_n, s_col, s_frame_done, s_stable} !== {e_row_n, e_col, e_fd, m_stable}) begin
                n_err++;
                $display("FAIL random c%0d: row_n/col/fd/st/cnt=%h/%h/%b/%b/%0d need %h/%h/%b/%b/%0d small=%0d/%0d",
                         i, row_n, col, frame_done, stable, gen_count,
                         e_row_n, e_col, e_fd, m_stable, m_count, s_gen_count, exp_s);
            end
        end
        grid_valid = 1'b0; blank = 1'b0;
    endtask

    task automatic test_reset_mid();
        int budget;
        budget = 2 * FRAME;
        while (!(m_scan && (m_pos / SLOT) == 5 && (m_pos % SLOT) >= GAP + 1) && budget > 0) begin
            tick(); budget--;
        end
        n_cmp++;
        if (row_n !== 8'hDF) begin
            n_err++;
            $display("FAIL pre_reset_row5: row_n=%h need DF", row_n);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (row_n !== 8'hFF || col !== 8'h00 || frame_done !== 1'b0 ||
            gen_count !== 16'd0 || s_gen_count !== 3'd0) begin
            n_err++;
            $display("FAIL async_reset: row_n=%h col=%h fd=%b cnt=%0d small=%0d need FF 00 0 0 0",
                     row_n, col, frame_done, gen_count, s_gen_count);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (row_n !== 8'hFF || col !== 8'h00 || frame_done !== 1'b0 || gen_count !== 16'd0) begin
                n_err++;
                $display("FAIL post_reset_idle c%0d: row_n=%h col=%h fd=%b cnt=%0d need FF 00 0 0",
                         i, row_n, col, frame_done, gen_count);
            end
        end
        grid = {$urandom, $urandom}; grid_valid = 1'b1;
        tick();
        grid_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_cmp++;
            if ({row_n, col, frame_done} !== {e_row_n, e_col, e_fd} || gen_count !== 16'd1) begin
                n_err++;
                $display("FAIL restart c%0d: row_n/col/fd/cnt=%h/%h/%b/%0d need %h/%h/%b/1",
                         i, row_n, col, frame_done, gen_count, e_row_n, e_col, e_fd);
            end
        end
    endtask

    initial begin
        reset = 1'b1; grid = '0; grid_valid = 1'b0; blank = 1'b0;
        model_reset();
        test_reset();
        test_first_frame();
        test_mid_frame();
        test_stable();
        test_back_to_back();
        test_bypass();
        test_blank();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
